sent_tx_serial_msg_sched: RTL

- Sequences SAE J2716 slow-channel serial messages across consecutive SENT fast frames.
- Snapshots the serial ID/data inputs and obtains the serial CRC from sent_tx_crc_gen.
- On each frame start, drives status-nibble bits [3:2] for that frame.
- Sits beside sent_tx_control, which sends status_nibble as the status/communication nibble of every frame.

---
 rtl/sent_tx_serial_msg_sched.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sent_tx_serial_msg_sched.sv
// SENT slow-channel serial message scheduler: spreads one short (16-frame) or
// enhanced (18-frame) serial message over status-nibble bits [3:2] of consecutive fast frames.
module sent_tx_serial_msg_sched #(
    parameter int SHORT_FRAMES = 16,
    parameter int ENH_FRAMES   = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        channel_format,
    input  logic        config_bit,
    input  logic [3:0]  id_4bit,
    input  logic [7:0]  id_8bit,
    input  logic [11:0] data_12bit,
    input  logic [15:0] data_16bit,
    input  logic [7:0]  data_short,
    input  logic [1:0]  app_status,
    input  logic        frame_start,
    output logic        enable_crc_serial,
    output logic        enable_crc_enhanced,
    output logic [11:0] data_short_to_crc,
    output logic [23:0] data_enhanced_to_crc,
    input  logic [3:0]  crc_serial,
    input  logic [5:0]  crc_enhanced,
    output logic [3:0]  status_nibble,
    output logic        msg_busy,
    output logic        msg_done,
    output logic [4:0]  frame_idx
);

    typedef enum logic [1:0] {IDLE, LATCH, CRC_WAIT, RUN} state_t;

    state_t      state, next_state;
    logic        fmt_q, cfg_q;
    logic [3:0]  id4_q;
    logic [7:0]  id8_q;
    logic [11:0] d12_q;
    logic [15:0] d16_q;
    logic [7:0]  dshort_q;
    logic [3:0]  crc4_q;
    logic [5:0]  crc6_q;

    logic [11:0] enh_d;
    logic [3:0]  enh_x, enh_y;
    logic [17:0] enh_b2, enh_b3;
    logic [15:0] short_b2;
    logic [4:0]  enh_pos;
    logic [3:0]  short_pos;
    logic        b2_bit, b3_bit, last_frame;

    // Field mapping depends on the enhanced config bit C.
    assign enh_d    = cfg_q ? d16_q[11:0]  : d12_q;
    assign enh_x    = cfg_q ? d16_q[15:12] : id8_q[7:4];
    assign enh_y    = cfg_q ? id4_q        : id8_q[3:0];
    assign enh_b2   = {crc6_q, enh_d};
    assign enh_b3   = {6'b111111, 1'b0, cfg_q, enh_x, 1'b0, enh_y, 1'b0};
    assign short_b2 = {id4_q, dshort_q, crc4_q};

    // Frame 0 carries the MSB of each sequence.
    assign enh_pos    = 5'(ENH_FRAMES - 1) - frame_idx;
    assign short_pos  = 4'(SHORT_FRAMES - 1) - frame_idx[3:0];
    assign b2_bit     = fmt_q ? enh_b2[enh_pos] : short_b2[short_pos];
    assign b3_bit     = fmt_q ? enh_b3[enh_pos] : (frame_idx == 5'd0);
    assign last_frame = fmt_q ? (frame_idx == 5'(ENH_FRAMES - 1))
                              : (frame_idx == 5'(SHORT_FRAMES - 1));

    assign data_short_to_crc = {id4_q, dshort_q};

    // CRC covers frames 6..17 only, which hold no CRC bits themselves.
    always_comb begin
        data_enhanced_to_crc = '0;
        for (int k = 0; k < 12; k++) begin
            data_enhanced_to_crc[23 - 2*k] = enh_b3[11 - k];
            data_enhanced_to_crc[22 - 2*k] = enh_b2[11 - k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (enable) next_state = LATCH;
            LATCH:    next_state = CRC_WAIT;
            CRC_WAIT: next_state = RUN;
            RUN:      if (frame_start && last_frame) next_state = enable ? LATCH : IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        enable_crc_serial   = 1'b0;
        enable_crc_enhanced = 1'b0;
        msg_busy            = (state != IDLE);
        if (state == LATCH) begin
            enable_crc_serial   = ~fmt_q;
            enable_crc_enhanced = fmt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fmt_q         <= 1'b0;
            cfg_q         <= 1'b0;
            id4_q         <= '0;
            id8_q         <= '0;
            d12_q         <= '0;
            d16_q         <= '0;
            dshort_q      <= '0;
            crc4_q        <= '0;
            crc6_q        <= '0;
            status_nibble <= '0;
            msg_done      <= 1'b0;
            frame_idx     <= '0;
        end else begin
            msg_done <= 1'b0;
            // Snapshot once per message; inputs are ignored until the next LATCH.
            if (next_state == LATCH) begin
                fmt_q    <= channel_format;
                cfg_q    <= config_bit;
                id4_q    <= id_4bit;
                id8_q    <= id_8bit;
                d12_q    <= data_12bit;
                d16_q    <= data_16bit;
                dshort_q <= data_short;
            end
            if (state == CRC_WAIT) begin
                if (fmt_q) crc6_q <= crc_enhanced;
                else       crc4_q <= crc_serial;
                frame_idx <= '0;
            end
            if (frame_start) begin
                if (state == RUN) begin
                    status_nibble <= {b3_bit, b2_bit, app_status};
                    if (last_frame) begin
                        msg_done  <= 1'b1;
                        frame_idx <= '0;
                    end else begin
                        frame_idx <= frame_idx + 5'd1;
                    end
                end else begin
                    status_nibble <= {2'b00, app_status};
                end
            end
        end
    end

endmodule
